// File: rtl/puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF response reader.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    WAIT   = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int N_CHAL_DEF = 16;
  localparam int CNT_W_DEF  = 16;
  localparam int WINDOW_DEF = 1024;
  localparam int SETTLE_DEF = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Down-counter shared by the CLEAR, RUN and WAIT phases; done marks the last counted cycle.
module puf_window_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Reload takes priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (enable && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end
  end

  assign done = enable && (cnt_r == W'(1));

endmodule

// File: rtl/puf_challenge_reader.sv
// Steps through all challenges, races the oscillator pair per challenge and
// assembles the comparison results into one response word with valid/ready handoff.
module puf_challenge_reader
  import puf_pkg::*;
#(
  parameter int N_CHAL = N_CHAL_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int CHAL_W = clog2(N_CHAL),
  parameter int TIE_W  = clog2(N_CHAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [CHAL_W-1:0] challenge,
  output logic              osc_en,
  output logic              cnt_clr,
  input  logic [CNT_W-1:0]  count_a,
  input  logic [CNT_W-1:0]  count_b,
  output logic [N_CHAL-1:0] resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [TIE_W-1:0]  tie_cnt,
  output logic              sat
);

  localparam int TMR_W = clog2(((WINDOW > SETTLE) ? WINDOW : SETTLE) + 1);
  localparam logic [CHAL_W-1:0] LAST_CHAL = CHAL_W'(N_CHAL - 1);

  state_t              state_r, next_state_s;
  logic                tmr_load_s, tmr_en_s, tmr_done_s;
  logic [TMR_W-1:0]    tmr_val_s;
  logic [CHAL_W-1:0]   challenge_r;
  logic [N_CHAL-1:0]   resp_r;
  logic [TIE_W-1:0]    tie_r;
  logic                sat_r, busy_r, osc_en_r, cnt_clr_r, resp_valid_r;

  puf_window_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .enable   (tmr_en_s),
    .done     (tmr_done_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and timer control; each timed phase loads the length of the phase it enters.
  always_comb begin
    next_state_s = state_r;
    tmr_load_s   = 1'b0;
    tmr_en_s     = 1'b0;
    tmr_val_s    = '0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = CLEAR;
          tmr_load_s   = 1'b1;
          tmr_val_s    = TMR_W'(SETTLE);
        end else begin
          next_state_s = IDLE;
        end
      end
      CLEAR: begin
        tmr_en_s = 1'b1;
        if (tmr_done_s) begin
          next_state_s = RUN;
          tmr_load_s   = 1'b1;
          tmr_val_s    = TMR_W'(WINDOW);
        end else begin
          next_state_s = CLEAR;
        end
      end
      RUN: begin
        tmr_en_s = 1'b1;
        if (tmr_done_s) begin
          next_state_s = WAIT;
          tmr_load_s   = 1'b1;
          tmr_val_s    = TMR_W'(SETTLE);
        end else begin
          next_state_s = RUN;
        end
      end
      WAIT: begin
        tmr_en_s = 1'b1;
        if (tmr_done_s) begin
          next_state_s = SAMPLE;
        end else begin
          next_state_s = WAIT;
        end
      end
      SAMPLE: begin
        if (challenge_r == LAST_CHAL) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CLEAR;
          tmr_load_s   = 1'b1;
          tmr_val_s    = TMR_W'(SETTLE);
        end
      end
      DONE: begin
        if (resp_valid_r && resp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Response datapath: cleared on run start, updated once per challenge in SAMPLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      challenge_r <= '0;
      resp_r      <= '0;
      tie_r       <= '0;
      sat_r       <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      challenge_r <= '0;
      resp_r      <= '0;
      tie_r       <= '0;
      sat_r       <= 1'b0;
    end else if (state_r == SAMPLE) begin
      resp_r[challenge_r] <= (count_a > count_b);
      if (count_a == count_b) begin
        tie_r <= tie_r + TIE_W'(1);
      end
      if ((&count_a) || (&count_b)) begin
        sat_r <= 1'b1;
      end
      if (challenge_r != LAST_CHAL) begin
        challenge_r <= challenge_r + CHAL_W'(1);
      end
    end
  end

  // Control outputs registered from the next state so they track the FSM cycle-for-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      osc_en_r     <= 1'b0;
      cnt_clr_r    <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      busy_r       <= (next_state_s != IDLE);
      osc_en_r     <= (next_state_s == RUN);
      cnt_clr_r    <= (next_state_s == CLEAR);
      resp_valid_r <= (state_r == DONE) && !(resp_valid_r && resp_ready);
    end
  end

  assign busy       = busy_r;
  assign challenge  = challenge_r;
  assign osc_en     = osc_en_r;
  assign cnt_clr    = cnt_clr_r;
  assign resp       = resp_r;
  assign resp_valid = resp_valid_r;
  assign tie_cnt    = tie_r;
  assign sat        = sat_r;

endmodule

// File: tb/tb_puf_challenge_reader.sv
// Self-checking bench: table-driven runs, reset/busy corner sequences and randomized runs vs a response model.
module tb_puf_challenge_reader;

  logic            clk = 1'b0;
  logic            rst_n, start, resp_ready;
  logic            busy, osc_en, cnt_clr, resp_valid, sat;
  logic [1:0]      challenge;
  logic [7:0]      count_a, count_b;
  logic [3:0]      resp;
  logic [2:0]      tie_cnt;
  logic [3:0][7:0] cur_a, cur_b;
  int              total = 0;
  int              bad = 0;
  int              hs_cnt = 0;

  always #5 clk = ~clk;

  puf_challenge_reader #(.N_CHAL(4), .CNT_W(8), .WINDOW(8), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .challenge(challenge),
    .osc_en(osc_en), .cnt_clr(cnt_clr), .count_a(count_a), .count_b(count_b),
    .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .tie_cnt(tie_cnt), .sat(sat)
  );

  // Counter model: cleared while cnt_clr, otherwise the per-challenge final count.
  always_comb begin
    count_a = cnt_clr ? 8'd0 : cur_a[challenge];
    count_b = cnt_clr ? 8'd0 : cur_b[challenge];
  end

  always @(posedge clk) begin
    if (resp_valid && resp_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                                output logic [3:0] r, output logic [2:0] t, output logic s);
    r = 4'd0; t = 3'd0; s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r[i] = (int'(a[i]) > int'(b[i]));
      if (a[i] == b[i]) t = t + 3'd1;
      if (a[i] == 8'hFF || b[i] == 8'hFF) s = 1'b1;
    end
  endfunction

  task automatic do_run(input logic [3:0][7:0] a, input logic [3:0][7:0] b, input bit hold,
                        input int bp, input bit poke,
                        output logic [3:0] r, output logic [2:0] t, output logic s);
    int cyc, clr_n, en_n, glitch, chg, h0;
    cur_a = a; cur_b = b; h0 = hs_cnt;
    @(negedge clk); resp_ready = hold; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; clr_n = 0; en_n = 0; glitch = 0;
    while (!resp_valid && cyc < 2000) begin
      if (cyc < 13) begin
        clr_n += int'(cnt_clr);
        en_n  += int'(osc_en);
        if ((cyc == 10 || cyc == 11) && osc_en) glitch++;
      end
      if (cyc < 52 && challenge != 2'(cyc / 13)) glitch++;
      if (poke) start = (cyc == 5);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    check("latency", cyc, 53);
    check("slot0_clr_cycles", clr_n, 2);
    check("slot0_en_cycles", en_n, 8);
    check("challenge_seq_and_wait", glitch, 0);
    r = resp; t = tie_cnt; s = sat;
    if (bp > 0) begin
      chg = 0;
      for (int i = 0; i < bp; i++) begin
        start = poke && (i == 3);
        @(negedge clk);
        if (!resp_valid || resp !== r) chg++;
      end
      start = 1'b0;
      check("backpressure_hold", chg, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
    check("valid_drop", resp_valid, 0);
    check("idle_busy", busy, 0);
    check("resp_retained", resp, r);
    repeat (3) @(negedge clk);
    check("stay_idle", busy, 0);
    check("one_handshake", hs_cnt - h0, 1);
  endtask

  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    bit              hold;
    int              bp;
    bit              poke;
    logic [3:0]      er;
    logic [2:0]      et;
    logic            es;
  } vec_t;

  vec_t       tbl[4];
  logic [3:0] gr, mr;
  logic [2:0] gt, mt;
  logic       gs, ms;

  initial begin
    // slot order in the packed literal is {slot3, slot2, slot1, slot0}
    tbl[0] = '{a: {8'd200, 8'd7, 8'd3, 8'd10}, b: {8'd1, 8'd7, 8'd9, 8'd5},
               hold: 1'b1, bp: 0, poke: 1'b0, er: 4'b1001, et: 3'd1, es: 1'b0};
    tbl[1] = '{a: {8'd5, 8'hFF, 8'd0, 8'd1}, b: {8'd5, 8'd3, 8'd0, 8'd2},
               hold: 1'b0, bp: 20, poke: 1'b0, er: 4'b0100, et: 3'd2, es: 1'b1};
    tbl[2] = '{a: {8'd9, 8'd9, 8'd9, 8'd9}, b: {8'd8, 8'd8, 8'd8, 8'd8},
               hold: 1'b0, bp: 0, poke: 1'b0, er: 4'b1111, et: 3'd0, es: 1'b0};
    tbl[3] = '{a: {8'h80, 8'd0, 8'hFF, 8'd0}, b: {8'h7F, 8'd0, 8'hFF, 8'hFF},
               hold: 1'b0, bp: 6, poke: 1'b1, er: 4'b1000, et: 3'd2, es: 1'b1};

    rst_n = 1'b0; start = 1'b0; resp_ready = 1'b0;
    cur_a = '0; cur_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_osc_en", osc_en, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_outputs", {challenge, resp, tie_cnt, sat}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      do_run(tbl[v].a, tbl[v].b, tbl[v].hold, tbl[v].bp, tbl[v].poke, gr, gt, gs);
      check("tbl_resp", gr, tbl[v].er);
      check("tbl_tie", gt, tbl[v].et);
      check("tbl_sat", gs, tbl[v].es);
    end

    // Asynchronous reset during RUN of slot 1 (cycles 15..22 of the run).
    cur_a = tbl[0].a; cur_b = tbl[0].b;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (18) @(negedge clk);
    check("pre_reset_osc_en", osc_en, 1);
    check("pre_reset_challenge", challenge, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_osc_en", osc_en, 0);
    check("async_ctrl", {busy, cnt_clr, resp_valid}, 0);
    check("async_outputs", {challenge, resp, tie_cnt, sat}, 0);
    @(negedge clk); rst_n = 1'b1;
    do_run(tbl[0].a, tbl[0].b, 1'b0, 0, 1'b0, gr, gt, gs);
    check("post_reset_resp", gr, 4'b1001);
    check("post_reset_tie", gt, 3'd1);
    check("post_reset_sat", gs, 1'b0);

    for (int n = 0; n < 6; n++) begin
      logic [3:0][7:0] ra, rb;
      for (int i = 0; i < 4; i++) begin
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
        case ($urandom_range(0, 3))
          0: rb[i] = ra[i];
          1: ra[i] = 8'hFF;
          2: rb[i] = 8'hFF;
          default: ;
        endcase
      end
      model(ra, rb, mr, mt, ms);
      do_run(ra, rb, n[0], (n == 2) ? 4 : 0, 1'b0, gr, gt, gs);
      check("rand_resp", gr, mr);
      check("rand_tie", gt, mt);
      check("rand_sat", gs, ms);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
